// File: rtl/csr_pkg.sv
// Shared encodings for the machine-level CSR unit.
// Op codes, CSR addresses, cause codes and FSM states.
package csr_pkg;

    localparam logic [2:0] OP_EXC   = 3'b000;
    localparam logic [2:0] OP_MRET  = 3'b001;
    localparam logic [2:0] OP_CSRRW = 3'b101;
    localparam logic [2:0] OP_CSRRS = 3'b110;
    localparam logic [2:0] OP_CSRRC = 3'b111;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MEXTIE   = 12'h7C0;
    localparam logic [11:0] CSR_MEXTIP   = 12'h7C1;
    localparam logic [11:0] CSR_MEXTID   = 12'h7C2;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_PROGRESS,
        ST_DONE
    } state_t;

    // New CSR value for read-write, read-set and read-clear.
    function automatic logic [31:0] csr_apply(
        input logic [2:0]  op,
        input logic [31:0] old,
        input logic [31:0] opnd
    );
        logic [31:0] res;
        res = opnd;
        if (op == OP_CSRRS) res = old | opnd;
        if (op == OP_CSRRC) res = old & ~opnd;
        return res;
    endfunction

endpackage

// File: rtl/csr_machine_irq_edge_capture.sv
// Rising-edge capture and pending bits for external interrupt lines.
// Also picks the lowest-index line that is both pending and enabled.
module irq_edge_capture #(
    parameter int unsigned NUM_EXT_IRQ = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_EXT_IRQ-1:0] i_lines,
    input  logic [NUM_EXT_IRQ-1:0] i_en,
    input  logic [NUM_EXT_IRQ-1:0] i_clr,
    output logic [NUM_EXT_IRQ-1:0] o_pend,
    output logic                   o_found,
    output logic [3:0]             o_idx
);

    logic [NUM_EXT_IRQ-1:0] r_prev;
    logic [NUM_EXT_IRQ-1:0] r_pend;
    logic [NUM_EXT_IRQ-1:0] w_rise;
    logic [NUM_EXT_IRQ-1:0] w_req;

    assign w_rise = i_lines & ~r_prev;
    assign w_req  = r_pend & i_en;
    assign o_pend = r_pend;

    // Track line history; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= i_lines;
            r_pend <= (r_pend & ~i_clr) | w_rise;
        end
    end

    // Lowest-index pending and enabled line wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 4'd0;
        for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                o_found = 1'b1;
                o_idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/csr_machine_irq.sv
// Machine-mode CSR unit with edge-captured external interrupts.
// Optional 64-bit mcycle counter under CSR_CYCLE_COUNTER_EN.
module csr_machine_irq
    import csr_pkg::*;
#(
    parameter logic [31:0] IRQ_HANDLER_ADDR = 32'h00000010,
    parameter int unsigned NUM_EXT_IRQ      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   available,
    input  logic [2:0]             op,
    input  logic [11:0]            addr_exception,
    input  logic [31:0]            write_value,
    input  logic [NUM_EXT_IRQ-1:0] ext_int,
    output logic [31:0]            read_value,
    output logic                   irq_pending,
    output logic                   busy,
    output logic                   fault
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_busy;
    logic   w_busy_nxt;
    logic   w_exec;
    logic   w_fault_clr;

    logic [31:0] r_rv;
    logic        r_fault;
    logic        r_irq;

    logic        r_mie;
    logic        r_mpie;
    logic        r_meie;
    logic        r_msie;
    logic        r_msip;
    logic [29:0] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [3:0]  r_mextid;
    logic [NUM_EXT_IRQ-1:0] r_en;

`ifdef CSR_CYCLE_COUNTER_EN
    logic [63:0] r_mcycle;
`endif

    logic [NUM_EXT_IRQ-1:0] w_pend;
    logic [NUM_EXT_IRQ-1:0] w_clr;
    logic [NUM_EXT_IRQ-1:0] w_onehot;
    logic                   w_found;
    logic [3:0]             w_idx;
    logic                   w_meip;

    logic        w_is_int;
    logic [3:0]  w_code;
    logic        w_is_mei;
    logic [31:0] w_trap;
    logic        w_is_csr;
    logic        w_wr;
    logic [31:0] w_old;
    logic        w_hit;
    logic        w_ro;
    logic [31:0] w_new;
    logic        w_commit;
    logic [31:0] w_rv;
    logic        w_fault;

    assign read_value  = r_rv;
    assign fault       = r_fault;
    assign busy        = r_busy;
    assign irq_pending = r_irq;

    assign w_is_int = addr_exception[4];
    assign w_code   = addr_exception[3:0];
    assign w_is_mei = w_is_int && (w_code == CAUSE_MEI);
    assign w_meip   = |(w_pend & r_en);

    assign w_is_csr = (op == OP_CSRRW) || (op == OP_CSRRS) ||
                      (op == OP_CSRRC);
    assign w_wr     = (op == OP_CSRRW) || (write_value != 32'd0);
    assign w_new    = csr_apply(op, w_old, write_value);
    assign w_commit = w_exec && w_is_csr && w_hit && w_wr && !w_ro;

    irq_edge_capture #(
        .NUM_EXT_IRQ(NUM_EXT_IRQ)
    ) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_lines (ext_int),
        .i_en    (r_en),
        .i_clr   (w_clr),
        .o_pend  (w_pend),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // FSM state and busy register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next state: accept, execute once, then wait for request drop.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_exec      = 1'b0;
        w_fault_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (available) begin
                    w_state_nxt = ST_IN_PROGRESS;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_IN_PROGRESS: begin
                w_exec      = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (available) begin
                    w_busy_nxt = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                    w_fault_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // CSR read mux plus write-protection for the addressed register.
    always_comb begin
        w_old = 32'd0;
        w_hit = 1'b1;
        w_ro  = 1'b0;
        case (addr_exception)
            CSR_MSTATUS: begin
                w_old[3] = r_mie;
                w_old[7] = r_mpie;
            end
            CSR_MIE: begin
                w_old[3]  = r_msie;
                w_old[11] = r_meie;
            end
            CSR_MTVEC:    w_old = {r_mtvec_base, 1'b0, r_mtvec_mode};
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC: begin
                w_old = r_mepc;
                w_ro  = 1'b1;
            end
            CSR_MCAUSE: begin
                w_old = r_mcause;
                w_ro  = 1'b1;
            end
            CSR_MIP: begin
                w_old[3]  = r_msip;
                w_old[11] = w_meip;
            end
            CSR_MEXTIE: w_old[NUM_EXT_IRQ-1:0] = r_en;
            CSR_MEXTIP: begin
                w_old[NUM_EXT_IRQ-1:0] = w_pend;
                w_ro = (op != OP_CSRRC);
            end
            CSR_MEXTID: begin
                w_old[3:0] = r_mextid;
                w_ro       = 1'b1;
            end
`ifdef CSR_CYCLE_COUNTER_EN
            CSR_MCYCLE: begin
                w_old = r_mcycle[31:0];
                w_ro  = 1'b1;
            end
            CSR_MCYCLEH: begin
                w_old = r_mcycle[63:32];
                w_ro  = 1'b1;
            end
`endif
            default: w_hit = 1'b0;
        endcase
    end

    // Trap target: direct base, or vectored slot for interrupts.
    always_comb begin
        w_trap = {r_mtvec_base, 2'b00};
        if (r_mtvec_mode && w_is_int) begin
            w_trap = {r_mtvec_base, 2'b00} + {26'd0, w_code, 2'b00};
        end
    end

    // Result and fault for the executing op.
    always_comb begin
        w_rv    = r_rv;
        w_fault = 1'b0;
        case (op)
            OP_EXC:  w_rv = w_trap;
            OP_MRET: w_rv = r_mepc;
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                w_rv    = w_old;
                w_fault = !w_hit || (w_wr && w_ro);
            end
            default: w_fault = 1'b1;
        endcase
    end

    // Pending clears: serviced MEI line, or RC on mextip.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_EXT_IRQ; i++) begin
            w_onehot[i] = (w_idx == 4'(i));
        end
        w_clr = '0;
        if (w_exec && (op == OP_EXC) && w_is_mei && w_found) begin
            w_clr = w_onehot;
        end else if (w_commit && (addr_exception == CSR_MEXTIP)) begin
            w_clr = write_value[NUM_EXT_IRQ-1:0];
        end
    end

    // Result registers; fault drops when the request is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rv    <= 32'd0;
            r_fault <= 1'b0;
        end else if (w_exec) begin
            r_rv    <= w_rv;
            r_fault <= w_fault;
        end else if (w_fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    // Architectural state updates on exception, MRET and CSR writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_meie       <= 1'b0;
            r_msie       <= 1'b0;
            r_msip       <= 1'b0;
            r_mtvec_base <= IRQ_HANDLER_ADDR[31:2];
            r_mtvec_mode <= 1'b0;
            r_mscratch   <= 32'd0;
            r_mepc       <= 32'd0;
            r_mcause     <= 32'd0;
            r_mextid     <= 4'd0;
            r_en         <= '0;
        end else if (w_exec && (op == OP_EXC)) begin
            r_mepc   <= write_value;
            r_mcause <= {w_is_int, 27'd0, w_code};
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            if (w_is_mei && w_found) r_mextid <= w_idx;
        end else if (w_exec && (op == OP_MRET)) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_commit) begin
            case (addr_exception)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                CSR_MIE: begin
                    r_msie <= w_new[3];
                    r_meie <= w_new[11];
                end
                CSR_MTVEC: begin
                    r_mtvec_base <= w_new[31:2];
                    r_mtvec_mode <= w_new[0];
                end
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MIP:      r_msip <= w_new[3];
                CSR_MEXTIE:   r_en <= w_new[NUM_EXT_IRQ-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt request, registered from current enables and pendings.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_mie && ((r_meie && w_meip) || (r_msie && r_msip));
        end
    end

`ifdef CSR_CYCLE_COUNTER_EN
    // Free-running cycle counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcycle <= 64'd0;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_machine_irq.sv
// Directed self-checking bench for csr_machine_irq.
// Each step drives one op and checks hand-computed results.
module tb_csr_machine_irq;
    import csr_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        available;
    logic [2:0]  op;
    logic [11:0] addr_exception;
    logic [31:0] write_value;
    logic [3:0]  ext_int;
    logic [31:0] read_value;
    logic        irq_pending;
    logic        busy;
    logic        fault;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] rv_s;
    logic        fault_s;
    logic        busy_s;

    csr_machine_irq dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .available      (available),
        .op             (op),
        .addr_exception (addr_exception),
        .write_value    (write_value),
        .ext_int        (ext_int),
        .read_value     (read_value),
        .irq_pending    (irq_pending),
        .busy           (busy),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    // Request, sample result after the execute edge, then release.
    task automatic do_op(input logic [2:0] o, input logic [11:0] a,
                         input logic [31:0] w);
        @(negedge clk);
        available      = 1'b1;
        op             = o;
        addr_exception = a;
        write_value    = w;
        @(posedge clk);
        @(posedge clk);
        #1;
        rv_s    = read_value;
        fault_s = fault;
        busy_s  = busy;
        available = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        available      = 1'b0;
        op             = 3'b000;
        addr_exception = 12'h000;
        write_value    = 32'h0;
        ext_int        = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rv", read_value, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'h0);
        chk("rst_irq", {31'd0, irq_pending}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // mtvec reset value and write-back
        do_op(OP_CSRRS, CSR_MTVEC, 32'h0);
        chk("mtvec_rst", rv_s, 32'h00000010);
        chk("mtvec_rst_f", {31'd0, fault_s}, 32'h0);
        chk("res_busy", {31'd0, busy_s}, 32'h0);
        do_op(OP_CSRRW, CSR_MTVEC, 32'h00000101);
        chk("mtvec_rw_old", rv_s, 32'h00000010);
        do_op(OP_CSRRS, CSR_MTVEC, 32'h0);
        chk("mtvec_new", rv_s, 32'h00000101);

        // vectored external interrupt on line 2
        do_op(OP_CSRRS, CSR_MSTATUS, 32'h8);
        do_op(OP_CSRRS, CSR_MIE, 32'h800);
        do_op(OP_CSRRW, CSR_MEXTIE, 32'h4);
        chk("irq_before", {31'd0, irq_pending}, 32'h0);
        @(negedge clk);
        ext_int = 4'b0100;
        @(negedge clk);
        ext_int = 4'b0000;
        @(posedge clk);
        #1;
        chk("irq_set", {31'd0, irq_pending}, 32'h1);
        do_op(OP_CSRRS, CSR_MIP, 32'h0);
        chk("mip_meip", rv_s, 32'h00000800);
        do_op(OP_EXC, 12'h01B, 32'h00000080);
        chk("trap_vec", rv_s, 32'h0000012C);
        chk("trap_fault", {31'd0, fault_s}, 32'h0);
        chk("irq_clr", {31'd0, irq_pending}, 32'h0);
        do_op(OP_CSRRS, CSR_MEPC, 32'h0);
        chk("mepc", rv_s, 32'h00000080);
        do_op(OP_CSRRS, CSR_MEXTID, 32'h0);
        chk("mextid2", rv_s, 32'h2);
        do_op(OP_CSRRS, CSR_MCAUSE, 32'h0);
        chk("mcause", rv_s, 32'h8000000B);
        do_op(OP_CSRRS, CSR_MSTATUS, 32'h0);
        chk("mstatus_trap", rv_s, 32'h00000080);

        // two lines at once: lowest index serviced first
        do_op(OP_CSRRW, CSR_MEXTIE, 32'hA);
        chk("mextie_old", rv_s, 32'h4);
        @(negedge clk);
        ext_int = 4'b1010;
        @(negedge clk);
        ext_int = 4'b0000;
        do_op(OP_EXC, 12'h01B, 32'h00000090);
        chk("trap_vec2", rv_s, 32'h0000012C);
        do_op(OP_CSRRS, CSR_MEXTID, 32'h0);
        chk("mextid1", rv_s, 32'h1);
        do_op(OP_EXC, 12'h01B, 32'h000000A0);
        do_op(OP_CSRRS, CSR_MEXTID, 32'h0);
        chk("mextid3", rv_s, 32'h3);
        do_op(OP_CSRRS, CSR_MEXTIP, 32'h0);
        chk("mextip_empty", rv_s, 32'h0);

        // protection and illegal accesses
        do_op(OP_CSRRW, CSR_MEPC, 32'h5);
        chk("mepc_wr_f", {31'd0, fault_s}, 32'h1);
        chk("mepc_wr_rv", rv_s, 32'h000000A0);
        chk("fault_drop", {31'd0, fault}, 32'h0);
        do_op(OP_CSRRS, CSR_MEPC, 32'h0);
        chk("mepc_rd_f", {31'd0, fault_s}, 32'h0);
        chk("mepc_keep", rv_s, 32'h000000A0);
        do_op(OP_CSRRW, 12'h7FF, 32'h1);
        chk("unk_rv", rv_s, 32'h0);
        chk("unk_f", {31'd0, fault_s}, 32'h1);
        do_op(OP_CSRRW, CSR_MEXTIP, 32'h1);
        chk("mextip_rw_f", {31'd0, fault_s}, 32'h1);
        do_op(OP_CSRRW, CSR_MSCRATCH, 32'h12345678);
        do_op(OP_CSRRS, CSR_MSCRATCH, 32'h0);
        chk("mscratch", rv_s, 32'h12345678);
        do_op(3'b010, CSR_MSCRATCH, 32'h0);
        chk("badop_f", {31'd0, fault_s}, 32'h1);
        chk("badop_rv", rv_s, 32'h12345678);
        do_op(OP_CSRRS, CSR_MCYCLE, 32'h0);
`ifdef CSR_CYCLE_COUNTER_EN
        chk("mcycle_f", {31'd0, fault_s}, 32'h0);
`else
        chk("mcycle_f", {31'd0, fault_s}, 32'h1);
        chk("mcycle_rv", rv_s, 32'h0);
`endif

        // MRET restores MIE from MPIE
        do_op(OP_CSRRW, CSR_MSTATUS, 32'h80);
        do_op(OP_MRET, 12'h000, 32'h0);
        chk("mret_rv", rv_s, 32'h000000A0);
        do_op(OP_CSRRS, CSR_MSTATUS, 32'h0);
        chk("mret_mstatus", rv_s, 32'h00000088);

        // edge coinciding with a clear of the same line
        @(negedge clk);
        ext_int = 4'b0001;
        @(negedge clk);
        ext_int = 4'b0000;
        @(negedge clk);
        available      = 1'b1;
        op             = OP_CSRRC;
        addr_exception = CSR_MEXTIP;
        write_value    = 32'h1;
        @(posedge clk);
        @(negedge clk);
        ext_int = 4'b0001;
        @(posedge clk);
        #1;
        chk("rc_old", read_value, 32'h1);
        available = 1'b0;
        @(posedge clk);
        #1;
        do_op(OP_CSRRS, CSR_MEXTIP, 32'h0);
        chk("set_wins", rv_s, 32'h1);
        do_op(OP_CSRRC, CSR_MEXTIP, 32'h1);
        do_op(OP_CSRRS, CSR_MEXTIP, 32'h0);
        chk("level_no_edge", rv_s, 32'h0);
        ext_int = 4'b0000;

        // reset in the middle of an operation
        do_op(OP_CSRRW, CSR_MTVEC, 32'h00000200);
        @(negedge clk);
        available      = 1'b1;
        op             = OP_CSRRW;
        addr_exception = CSR_MTVEC;
        write_value    = 32'h00000300;
        @(posedge clk);
        #1;
        chk("inprog_busy", {31'd0, busy}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        chk("midrst_rv", read_value, 32'h0);
        available = 1'b0;
        reset_n   = 1'b1;
        do_op(OP_CSRRS, CSR_MTVEC, 32'h0);
        chk("midrst_mtvec", rv_s, 32'h00000010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
